// File: rtl/motor_json_formatter.sv
// JSON drive-command formatter: clamps L/R speeds, converts to BCD,
// and streams {"T":t,"L":sd.dd,"R":sd.dd}\n over valid/ready.
// Ports: clk, reset (sync, active-high); cmd_valid/cmd_ready with
// cmd_type, speed_l, speed_r; tx_data/tx_valid/tx_ready; frame_done.
// Optional macro MOTOR_JSON_DEDUP_EN drops repeats of the last frame.
module motor_json_formatter #(
  parameter int SPEED_W = 10,
  parameter int MAX_MAG = 100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [3:0]                cmd_type,
  input  logic signed [SPEED_W-1:0] speed_l,
  input  logic signed [SPEED_W-1:0] speed_r,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      frame_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SEND    = 2'd2
  } state_e;

  localparam logic [4:0] LAST_IDX = 5'd27;

  state_e             state_q;
  logic               cmd_ready_q;
  logic               tx_valid_q;
  logic               frame_done_q;
  logic [7:0]         tx_data_q;
  logic [4:0]         idx_q;
  logic [3:0]         cnt_q;
  logic [3:0]         typ_q;
  logic               neg_l_q;
  logic               neg_r_q;
  logic [SPEED_W-1:0] sh_l_q;
  logic [SPEED_W-1:0] sh_r_q;
  logic [11:0]        bcd_l_q;
  logic [11:0]        bcd_r_q;

  logic [3:0]         typ_d;
  logic [SPEED_W-1:0] mag_l_d;
  logic [SPEED_W-1:0] mag_r_d;
  logic [11:0]        bcd_l_d;
  logic [11:0]        bcd_r_d;
  logic [4:0]         idx_d;
  logic [7:0]         byte_d;
  logic               dup_d;
  logic               accept_d;
  logic               done_d;

  // Magnitude at SPEED_W+1 bits so the most negative input is safe.
  function automatic logic [SPEED_W-1:0] clamp_mag(
    input logic [SPEED_W-1:0] s
  );
    logic [SPEED_W:0] e;
    e = {s[SPEED_W-1], s};
    if (s[SPEED_W-1]) e = -e;
    if (16'(e) > 16'(MAX_MAG)) return SPEED_W'(MAX_MAG);
    return e[SPEED_W-1:0];
  endfunction

  // One shift-add-3 step over three BCD digits.
  function automatic logic [11:0] dab_step(
    input logic [11:0] b,
    input logic        in
  );
    logic [11:0] a;
    a = b;
    for (int i = 0; i < 3; i++) begin
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return {a[10:0], in};
  endfunction

  function automatic logic [7:0] asc(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  always_comb begin
    typ_d   = (cmd_type > 4'd9) ? 4'd9 : cmd_type;
    mag_l_d = clamp_mag(speed_l);
    mag_r_d = clamp_mag(speed_r);
    bcd_l_d = dab_step(bcd_l_q, sh_l_q[SPEED_W-1]);
    bcd_r_d = dab_step(bcd_r_q, sh_r_q[SPEED_W-1]);
  end

  // Next byte index skips a '-' slot when that field is not negative.
  always_comb begin
    idx_d = idx_q + 5'd1;
    if (idx_d == 5'd11 && !neg_l_q) idx_d = 5'd12;
    if (idx_d == 5'd21 && !neg_r_q) idx_d = 5'd22;
    byte_d = 8'h00;
    case (idx_d)
      5'd0:  byte_d = 8'h7b;
      5'd1:  byte_d = 8'h22;
      5'd2:  byte_d = 8'h54;
      5'd3:  byte_d = 8'h22;
      5'd4:  byte_d = 8'h3a;
      5'd5:  byte_d = asc(typ_q);
      5'd6:  byte_d = 8'h2c;
      5'd7:  byte_d = 8'h22;
      5'd8:  byte_d = 8'h4c;
      5'd9:  byte_d = 8'h22;
      5'd10: byte_d = 8'h3a;
      5'd11: byte_d = 8'h2d;
      5'd12: byte_d = asc(bcd_l_q[11:8]);
      5'd13: byte_d = 8'h2e;
      5'd14: byte_d = asc(bcd_l_q[7:4]);
      5'd15: byte_d = asc(bcd_l_q[3:0]);
      5'd16: byte_d = 8'h2c;
      5'd17: byte_d = 8'h22;
      5'd18: byte_d = 8'h52;
      5'd19: byte_d = 8'h22;
      5'd20: byte_d = 8'h3a;
      5'd21: byte_d = 8'h2d;
      5'd22: byte_d = asc(bcd_r_q[11:8]);
      5'd23: byte_d = 8'h2e;
      5'd24: byte_d = asc(bcd_r_q[7:4]);
      5'd25: byte_d = asc(bcd_r_q[3:0]);
      5'd26: byte_d = 8'h7d;
      5'd27: byte_d = 8'h0a;
      default: byte_d = 8'h00;
    endcase
  end

  assign accept_d = (state_q == IDLE) && cmd_valid && !dup_d;
  assign done_d   = (state_q == SEND) && tx_ready
                 && (idx_q == LAST_IDX);

`ifdef MOTOR_JSON_DEDUP_EN
  localparam int KW = 6 + 2 * SPEED_W;

  logic [KW-1:0] key_d;
  logic [KW-1:0] key_q;
  logic [KW-1:0] last_q;
  logic          last_vld_q;

  assign key_d = {typ_d, speed_l[SPEED_W-1], mag_l_d,
                  speed_r[SPEED_W-1], mag_r_d};
  assign dup_d = last_vld_q && (key_d == last_q);

  // Only a completed frame is remembered; reset forgets it, which also
  // covers frames abandoned by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q      <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      if (accept_d) key_q <= key_d;
      if (done_d) begin
        last_q     <= key_q;
        last_vld_q <= 1'b1;
      end
    end
  end
`else
  assign dup_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
      idx_q        <= 5'd0;
      cnt_q        <= 4'd0;
      typ_q        <= 4'd0;
      neg_l_q      <= 1'b0;
      neg_r_q      <= 1'b0;
      sh_l_q       <= '0;
      sh_r_q       <= '0;
      bcd_l_q      <= 12'd0;
      bcd_r_q      <= 12'd0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            state_q     <= CONVERT;
            cmd_ready_q <= 1'b0;
            cnt_q       <= 4'd0;
            typ_q       <= typ_d;
            neg_l_q     <= speed_l[SPEED_W-1];
            neg_r_q     <= speed_r[SPEED_W-1];
            sh_l_q      <= mag_l_d;
            sh_r_q      <= mag_r_d;
            bcd_l_q     <= 12'd0;
            bcd_r_q     <= 12'd0;
          end
        end
        CONVERT: begin
          bcd_l_q <= bcd_l_d;
          bcd_r_q <= bcd_r_d;
          sh_l_q  <= sh_l_q << 1;
          sh_r_q  <= sh_r_q << 1;
          cnt_q   <= cnt_q + 4'd1;
          if (cnt_q == 4'(SPEED_W - 1)) begin
            state_q    <= SEND;
            idx_q      <= 5'd0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= 8'h7b;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q      <= IDLE;
              idx_q        <= 5'd0;
              tx_valid_q   <= 1'b0;
              tx_data_q    <= 8'h00;
              frame_done_q <= 1'b1;
              cmd_ready_q  <= 1'b1;
            end else begin
              idx_q     <= idx_d;
              tx_data_q <= byte_d;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          tx_valid_q  <= 1'b0;
          tx_data_q   <= 8'h00;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_motor_json_formatter.sv
// Directed bench for motor_json_formatter: frame contents, latency,
// stalls, mid-frame reset, back-to-back and optional dedup.
module tb_motor_json_formatter;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd_type = 4'd0;
  logic signed [9:0] speed_l = '0;
  logic signed [9:0] speed_r = '0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              frame_done;

  int         n_tests = 0;
  int         n_fail = 0;
  int         fd_seen;
  int         unstable;
  int         cyc;
  int         lat;
  logic [7:0] got[$];

  motor_json_formatter #(
    .SPEED_W(10),
    .MAX_MAG(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_type(cmd_type),
    .speed_l(speed_l),
    .speed_r(speed_r),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [3:0] t, input int l,
                         input int r);
    cmd_type  = t;
    speed_l   = 10'(l);
    speed_r   = 10'(r);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid();
    lat = 1;
    while (!tx_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic capture(input bit stall, input bit poke);
    logic [7:0] pd;
    logic       pv;
    bit         done;
    got.delete();
    fd_seen  = 0;
    unstable = 0;
    cyc      = 0;
    done     = 0;
    while (!done && cyc < 400) begin
      tx_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      cmd_valid = poke && (cyc == 5);
      pv = tx_valid;
      pd = tx_data;
      tick();
      cyc++;
      if (frame_done) fd_seen++;
      if (pv && tx_ready) begin
        got.push_back(pd);
        if (pd == 8'h0a) done = 1;
      end else if (pv && (tx_valid !== 1'b1 || tx_data !== pd)) begin
        unstable++;
      end
    end
    cmd_valid = 1'b0;
    tx_ready  = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
    n_tests++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", tx_valid);
    end
    n_tests++;
    if (tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 00", tx_data);
    end
    n_tests++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b want 0", frame_done);
    end
  endtask

  task automatic test_neg_frame();
    string exp;
    int    bad;
    exp = "{\"T\":1,\"L\":-0.50,\"R\":-0.20}\n";
    request(4'd1, -50, -20);
    n_tests++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL neg_busy: cmd_ready %b want 0", cmd_ready);
    end
    wait_valid();
    n_tests++;
    if (lat != 11) begin
      n_fail++;
      $display("FAIL neg_latency: got %0d want 11", lat);
    end
    n_tests++;
    if (tx_data !== 8'h7b) begin
      n_fail++;
      $display("FAIL neg_first: got %h want 7b", tx_data);
    end
    capture(0, 0);
    bad = -1;
    for (int i = 0; i < got.size() && i < exp.len(); i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    n_tests++;
    if (got.size() != 28 || bad >= 0) begin
      n_fail++;
      $display("FAIL neg_bytes: len %0d want 28, bad idx %0d",
               got.size(), bad);
    end
    n_tests++;
    if (cyc != 28) begin
      n_fail++;
      $display("FAIL neg_rate: cycles %0d want 28", cyc);
    end
    n_tests++;
    if (fd_seen != 1 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL neg_done: pulses %0d rdy %b want 1 1",
               fd_seen, cmd_ready);
    end
    n_tests++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL neg_idle: v %b d %h want 0 00",
               tx_valid, tx_data);
    end
    tick();
    n_tests++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL neg_pulse: frame_done %b want 0", frame_done);
    end
  endtask

  task automatic test_zero();
    string exp;
    int    bad;
    exp = "{\"T\":0,\"L\":0.00,\"R\":0.00}\n";
    request(4'd0, 0, 0);
    wait_valid();
    capture(0, 0);
    bad = -1;
    for (int i = 0; i < got.size() && i < exp.len(); i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    n_tests++;
    if (got.size() != 26 || bad >= 0) begin
      n_fail++;
      $display("FAIL zero_bytes: len %0d want 26, bad idx %0d",
               got.size(), bad);
    end
  endtask

  task automatic test_clamp();
    string exp;
    int    bad;
    exp = "{\"T\":9,\"L\":-1.00,\"R\":1.00}\n";
    request(4'd12, -512, 300);
    wait_valid();
    capture(0, 0);
    bad = -1;
    for (int i = 0; i < got.size() && i < exp.len(); i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    n_tests++;
    if (got.size() != 27 || bad >= 0) begin
      n_fail++;
      $display("FAIL clamp_bytes: len %0d want 27, bad idx %0d",
               got.size(), bad);
    end
  endtask

  task automatic test_stall();
    string exp;
    int    bad;
    int    seen;
    exp = "{\"T\":9,\"L\":-1.00,\"R\":1.00}\n";
    request(4'd12, -512, 300);
    cmd_type = 4'd3;
    speed_l  = 10'sd5;
    speed_r  = 10'sd5;
    wait_valid();
    capture(1, 1);
    bad = -1;
    for (int i = 0; i < got.size() && i < exp.len(); i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    n_tests++;
    if (got.size() != 27 || bad >= 0) begin
      n_fail++;
      $display("FAIL stall_bytes: len %0d want 27, bad idx %0d",
               got.size(), bad);
    end
    n_tests++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL stall_hold: changes %0d want 0", unstable);
    end
    n_tests++;
    if (fd_seen != 1) begin
      n_fail++;
      $display("FAIL stall_done: pulses %0d want 1", fd_seen);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (tx_valid) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL stall_ignore: valid cycles %0d want 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    string exp;
    int    bad;
    int    fd;
    exp = "{\"T\":2,\"L\":0.75,\"R\":-0.03}\n";
    request(4'd2, 75, -3);
    wait_valid();
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    cmd_valid = 1'b1;
    tick();
    reset = 1'b0;
    cmd_valid = 1'b0;
    fd = frame_done ? 1 : 0;
    n_tests++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rmid_out: v %b d %h want 0 00",
               tx_valid, tx_data);
    end
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_ready: got %b want 1", cmd_ready);
    end
    tick();
    if (frame_done) fd++;
    n_tests++;
    if (fd != 0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_done: pulses %0d v %b want 0 0",
               fd, tx_valid);
    end
    request(4'd2, 75, -3);
    wait_valid();
    n_tests++;
    if (lat != 11) begin
      n_fail++;
      $display("FAIL rmid_latency: got %0d want 11", lat);
    end
    capture(0, 0);
    bad = -1;
    for (int i = 0; i < got.size() && i < exp.len(); i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    n_tests++;
    if (got.size() != 27 || bad >= 0) begin
      n_fail++;
      $display("FAIL rmid_bytes: len %0d want 27, bad idx %0d",
               got.size(), bad);
    end
  endtask

  task automatic test_back_to_back();
    string exp;
    int    bad;
    exp = "{\"T\":5,\"L\":1.00,\"R\":-1.00}\n";
    request(4'd5, 100, -100);
    wait_valid();
    capture(0, 0);
    bad = -1;
    for (int i = 0; i < got.size() && i < exp.len(); i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    n_tests++;
    if (got.size() != 27 || bad >= 0) begin
      n_fail++;
      $display("FAIL b2b_first: len %0d want 27, bad idx %0d",
               got.size(), bad);
    end
    exp = "{\"T\":5,\"L\":0.01,\"R\":0.01}\n";
    request(4'd5, 1, 1);
    n_tests++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: cmd_ready %b want 0", cmd_ready);
    end
    wait_valid();
    n_tests++;
    if (lat != 11) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d want 11", lat);
    end
    capture(0, 0);
    bad = -1;
    for (int i = 0; i < got.size() && i < exp.len(); i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    n_tests++;
    if (got.size() != 26 || bad >= 0) begin
      n_fail++;
      $display("FAIL b2b_second: len %0d want 26, bad idx %0d",
               got.size(), bad);
    end
  endtask

`ifdef MOTOR_JSON_DEDUP_EN
  task automatic test_dedup();
    string exp;
    int    bad;
    int    seen;
    exp = "{\"T\":1,\"L\":0.25,\"R\":0.25}\n";
    request(4'd1, 25, 25);
    wait_valid();
    capture(0, 0);
    bad = -1;
    for (int i = 0; i < got.size() && i < exp.len(); i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    n_tests++;
    if (got.size() != 26 || bad >= 0) begin
      n_fail++;
      $display("FAIL dedup_first: len %0d want 26, bad idx %0d",
               got.size(), bad);
    end
    tick();
    request(4'd1, 25, 25);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL dedup_ready: got %b want 1", cmd_ready);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid || frame_done) seen++;
      tick();
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL dedup_quiet: active cycles %0d want 0", seen);
    end
    exp = "{\"T\":1,\"L\":0.25,\"R\":0.26}\n";
    request(4'd1, 25, 26);
    wait_valid();
    capture(0, 0);
    bad = -1;
    for (int i = 0; i < got.size() && i < exp.len(); i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    n_tests++;
    if (got.size() != 26 || bad >= 0) begin
      n_fail++;
      $display("FAIL dedup_third: len %0d want 26, bad idx %0d",
               got.size(), bad);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_neg_frame();
    test_zero();
    test_clamp();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef MOTOR_JSON_DEDUP_EN
    test_dedup();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
